sipo_deser: RTL

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_shift.sv | 35 +++
 rtl/sipo_deser.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in / parallel-out deserializer.
// Holds the receiver state encoding and the default frame data width.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/sipo_shift.sv
// Data shift register for the deserializer: bits enter at the LSB end
// (so an MSB-first line leaves the word in natural order) while a running XOR tracks even parity.
module sipo_shift #(
    parameter int WIDTH = sipo_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] word,
    output logic             parity
);

    logic [WIDTH-1:0] shreg;
    logic             par_acc;

    // Every frame shifts exactly WIDTH bits, so only the parity accumulator
    // needs clearing at the start bit; the stale word is fully overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            par_acc <= 1'b0;
        end else if (clear) begin
            par_acc <= 1'b0;
        end else if (shift_en) begin
            shreg   <= {shreg[WIDTH-2:0], s_in};
            par_acc <= par_acc ^ s_in;
        end
    end

    assign word   = shreg;
    assign parity = par_acc;

endmodule

// File: rtl/sipo_deser.sv
// Framed serial receiver: start bit, WIDTH data bits MSB-first, even parity, stop bit.
// Good words land in a single holding register with a valid/ready handshake; faults pulse for one cycle.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic             rx_parity;
    logic             start_frame;
    logic             shift_en;
    logic             stop_eval;
    logic [WIDTH-1:0] data_word;
    logic             data_parity;
    logic             good_frame;
    logic             bad_parity;
    logic             bad_stop;
    logic             load_word;

    sipo_shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_frame),
        .shift_en(shift_en),
        .s_in    (s_in),
        .word    (data_word),
        .parity  (data_parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        stop_eval   = 1'b0;
        case (state)
            IDLE: begin
                if (!s_in) begin
                    start_frame = 1'b1;
                    next_state  = DATA;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    next_state = PARITY;
                end
            end
            PARITY: begin
                next_state = STOP;
            end
            STOP: begin
                stop_eval  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A bad stop bit masks any parity verdict, so the three outcomes never overlap.
    assign bad_stop   = stop_eval && !s_in;
    assign bad_parity = stop_eval && s_in && (rx_parity != data_parity);
    assign good_frame = stop_eval && s_in && (rx_parity == data_parity);
    assign load_word  = good_frame && (!p_valid || p_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_parity <= 1'b0;
        end else begin
            if (start_frame) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == PARITY) begin
                rx_parity <= s_in;
            end
        end
    end

    // Holding register: a same-cycle drain frees the slot for the incoming word.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_out      <= '0;
            p_valid    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= bad_parity;
            frame_err  <= bad_stop;
            overrun    <= good_frame && p_valid && !p_ready;
            if (load_word) begin
                p_out   <= data_word;
                p_valid <= 1'b1;
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end

endmodule
